uart_program_loader: RTL and testbench

- Controller that sits downstream of the UART receiver and sequences its byte stream into instruction/data memory writes for the Fibonacci microprocessor.
- Parses a framed protocol and packs bytes LSB-first into words:
  - SYNC 0xA5
  - ADDR
  - LEN
  - LEN words of data
  - XOR checksum
- Issues single-cycle memory writes, checks frame integrity, and releases the CPU (cpu_run) only after a clean load.

---
 rtl/uart_program_loader.sv | 168 ++++++++++++++++
 tb/tb_uart_program_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Frames the UART byte stream (SYNC, ADDR, LEN, data words, XOR checksum) into
// single-cycle memory writes and releases the CPU after a clean load.
module uart_program_loader #(
  parameter int DATA_WIDTH     = 8,
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  rx_done,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [1:0]            err_code,
  output logic                  cpu_run
);

  localparam int BPW   = WORD_WIDTH / DATA_WIDTH;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [DATA_WIDTH-1:0] SYNC_BYTE = DATA_WIDTH'(8'hA5);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(BPW - 1);
  localparam logic [CNT_W-1:0]      TERM_CNT  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHECK
  } state_t;

  typedef enum logic [1:0] {
    E_NONE    = 2'b00,
    E_CSUM    = 2'b01,
    E_TIMEOUT = 2'b10,
    E_ZLEN    = 2'b11
  } err_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [DATA_WIDTH-1:0]   word_cnt;
  logic [IDX_W-1:0]        byte_idx;
  logic [DATA_WIDTH-1:0]   csum;
  logic [CNT_W-1:0]        tmo_cnt;
  logic [WORD_WIDTH-1:0]   word_q;
  logic [WORD_WIDTH-1:0]   word_next;
  logic                    timed_out;

  // NOTE: every variable assigned in always_comb gets a full default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    word_next = word_q;
    word_next[int'(byte_idx)*DATA_WIDTH +: DATA_WIDTH] = rx_data;
  end

  // A byte arriving on the terminal count wins over the timeout.
  assign timed_out = (state != S_IDLE) && !rx_done && (tmo_cnt == TERM_CNT);

  // NOTE: sequential state uses non-blocking assignments only; later
  // assignments in the same block override earlier defaults for that edge.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      ptr_q     <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      csum      <= '0;
      tmo_cnt   <= '0;
      word_q    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_busy <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      err_code  <= E_NONE;
      cpu_run   <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;

      if (state == S_IDLE || rx_done) tmo_cnt <= '0;
      else                            tmo_cnt <= tmo_cnt + CNT_W'(1);

      if (timed_out) begin
        state     <= S_IDLE;
        load_busy <= 1'b0;
        load_err  <= 1'b1;
        err_code  <= E_TIMEOUT;
      end else if (rx_done) begin
        unique case (state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state     <= S_ADDR;
              load_busy <= 1'b1;
              load_err  <= 1'b0;
              err_code  <= E_NONE;
              cpu_run   <= 1'b0;
              csum      <= '0;
              byte_idx  <= '0;
            end
          end

          S_ADDR: begin
            ptr_q <= ADDR_WIDTH'(rx_data);
            csum  <= csum ^ rx_data;
            state <= S_LEN;
          end

          S_LEN: begin
            csum <= csum ^ rx_data;
            if (rx_data == '0) begin
              state     <= S_IDLE;
              load_busy <= 1'b0;
              load_err  <= 1'b1;
              err_code  <= E_ZLEN;
            end else begin
              word_cnt <= rx_data;
              byte_idx <= '0;
              state    <= S_DATA;
            end
          end

          S_DATA: begin
            csum   <= csum ^ rx_data;
            word_q <= word_next;
            if (byte_idx == LAST_IDX) begin
              mem_we    <= 1'b1;
              mem_addr  <= ptr_q;
              mem_wdata <= word_next;
              ptr_q     <= ptr_q + ADDR_WIDTH'(1);
              word_cnt  <= word_cnt - DATA_WIDTH'(1);
              byte_idx  <= '0;
              if (word_cnt == DATA_WIDTH'(1)) state <= S_CHECK;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end

          S_CHECK: begin
            state     <= S_IDLE;
            load_busy <= 1'b0;
            if (rx_data == csum) begin
              load_done <= 1'b1;
              cpu_run   <= 1'b1;
            end else begin
              load_err <= 1'b1;
              err_code <= E_CSUM;
            end
          end

          default: begin
            state     <= S_IDLE;
            load_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Table-driven bench for uart_program_loader plus hand-written timeout sequences.
module tb_uart_program_loader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        load_busy, load_done, load_err, cpu_run;
  logic [1:0]  err_code;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_program_loader #(
    .DATA_WIDTH(8), .WORD_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .arst_n(arst_n), .rx_done(rx_done), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
    .err_code(err_code), .cpu_run(cpu_run)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        dv;
    logic [7:0]  d;
    logic        we, busy, done, err;
    logic [1:0]  code;
    logic        run;
    logic        bus;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then look just after the rising edge.
  task automatic tick(input logic rst, input logic dv, input logic [7:0] d);
    @(negedge clk);
    arst_n  = rst;
    rx_done = dv;
    rx_data = d;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(input logic rst, input logic dv, input logic [7:0] d,
                             input logic we, input logic busy, input logic done,
                             input logic err, input logic [1:0] code, input logic run,
                             input logic bus, input logic [7:0] addr, input logic [31:0] wd);
    vec_t r;
    r.rst_n = rst; r.dv = dv; r.d = d;
    r.we = we; r.busy = busy; r.done = done; r.err = err; r.code = code; r.run = run;
    r.bus = bus; r.addr = addr; r.wdata = wd;
    return r;
  endfunction

  // Row in flight: busy, nothing else set.
  function automatic vec_t bz(input logic [7:0] d);
    return v(1, 1, d, 0, 1, 0, 0, 2'b00, 0, 0, 8'h00, 32'h0);
  endfunction

  initial begin
    // reset
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 0, 0, 2'b00, 0, 1, 8'h00, 32'h0));
    vecs.push_back(v(0, 1, 8'hA5, 0, 0, 0, 0, 2'b00, 0, 1, 8'h00, 32'h0));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 0, 0, 2'b00, 0, 1, 8'h00, 32'h0));
    // good frame, with a gap inside the data
    vecs.push_back(bz(8'hA5)); vecs.push_back(bz(8'h10)); vecs.push_back(bz(8'h01));
    vecs.push_back(bz(8'h11));
    vecs.push_back(v(1, 0, 8'h00, 0, 1, 0, 0, 2'b00, 0, 0, 8'h00, 32'h0));
    vecs.push_back(bz(8'h22)); vecs.push_back(bz(8'h33));
    vecs.push_back(v(1, 1, 8'h44, 1, 1, 0, 0, 2'b00, 0, 1, 8'h10, 32'h44332211));
    vecs.push_back(v(1, 0, 8'h00, 0, 1, 0, 0, 2'b00, 0, 1, 8'h10, 32'h44332211));
    vecs.push_back(v(1, 1, 8'h55, 0, 0, 1, 0, 2'b00, 1, 0, 8'h00, 32'h0));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 0, 0, 2'b00, 1, 0, 8'h00, 32'h0));
    // bad checksum
    vecs.push_back(bz(8'hA5)); vecs.push_back(bz(8'h10)); vecs.push_back(bz(8'h01));
    vecs.push_back(bz(8'h11)); vecs.push_back(bz(8'h22)); vecs.push_back(bz(8'h33));
    vecs.push_back(v(1, 1, 8'h44, 1, 1, 0, 0, 2'b00, 0, 1, 8'h10, 32'h44332211));
    vecs.push_back(v(1, 1, 8'h54, 0, 0, 0, 1, 2'b01, 0, 0, 8'h00, 32'h0));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 0, 1, 2'b01, 0, 0, 8'h00, 32'h0));
    // zero length, then resync clears the error
    vecs.push_back(bz(8'hA5)); vecs.push_back(bz(8'h20));
    vecs.push_back(v(1, 1, 8'h00, 0, 0, 0, 1, 2'b11, 0, 1, 8'h10, 32'h44332211));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 0, 1, 2'b11, 0, 0, 8'h00, 32'h0));
    vecs.push_back(bz(8'hA5));
    // reset after two data bytes
    vecs.push_back(bz(8'h50)); vecs.push_back(bz(8'h02));
    vecs.push_back(bz(8'h11)); vecs.push_back(bz(8'h22));
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 0, 0, 2'b00, 0, 1, 8'h00, 32'h0));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 0, 0, 2'b00, 0, 1, 8'h00, 32'h0));
    // fresh good frame
    vecs.push_back(bz(8'hA5)); vecs.push_back(bz(8'h40)); vecs.push_back(bz(8'h01));
    vecs.push_back(bz(8'hDE)); vecs.push_back(bz(8'hAD)); vecs.push_back(bz(8'hBE));
    vecs.push_back(v(1, 1, 8'hEF, 1, 1, 0, 0, 2'b00, 0, 1, 8'h40, 32'hEFBEADDE));
    vecs.push_back(v(1, 1, 8'h63, 0, 0, 1, 0, 2'b00, 1, 0, 8'h00, 32'h0));
    // garbage prefix leaves flags alone
    vecs.push_back(v(1, 1, 8'h00, 0, 0, 0, 0, 2'b00, 1, 0, 8'h00, 32'h0));
    vecs.push_back(v(1, 1, 8'hFF, 0, 0, 0, 0, 2'b00, 1, 0, 8'h00, 32'h0));
    vecs.push_back(v(1, 1, 8'h5A, 0, 0, 0, 0, 2'b00, 1, 1, 8'h40, 32'hEFBEADDE));
    // address wrap, with an in-payload A5 that must not resync
    vecs.push_back(bz(8'hA5)); vecs.push_back(bz(8'hFF)); vecs.push_back(bz(8'h02));
    vecs.push_back(bz(8'h01)); vecs.push_back(bz(8'h02)); vecs.push_back(bz(8'h03));
    vecs.push_back(v(1, 1, 8'h04, 1, 1, 0, 0, 2'b00, 0, 1, 8'hFF, 32'h04030201));
    vecs.push_back(bz(8'h05)); vecs.push_back(bz(8'h06)); vecs.push_back(bz(8'h07));
    vecs.push_back(v(1, 1, 8'hA5, 1, 1, 0, 0, 2'b00, 0, 1, 8'h00, 32'hA5070605));
    vecs.push_back(v(1, 1, 8'h58, 0, 0, 1, 0, 2'b00, 1, 0, 8'h00, 32'h0));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 0, 0, 2'b00, 1, 0, 8'h00, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].rst_n, vecs[i].dv, vecs[i].d);
      check($sformatf("row%0d ctl{we,busy,done,err,code,run}", i),
            64'({mem_we, load_busy, load_done, load_err, err_code, cpu_run}),
            64'({vecs[i].we, vecs[i].busy, vecs[i].done, vecs[i].err,
                 vecs[i].code, vecs[i].run}));
      if (vecs[i].bus)
        check($sformatf("row%0d bus{addr,wdata}", i),
              64'({mem_addr, mem_wdata}), 64'({vecs[i].addr, vecs[i].wdata}));
    end

    // Timeout: error exactly 100 cycles after the ADDR byte.
    tick(1, 1, 8'hA5);
    tick(1, 1, 8'h30);
    repeat (99) tick(1, 0, 8'h00);
    check("tmo cycle99 {busy,err}", 64'({load_busy, load_err}), 64'(2'b10));
    tick(1, 0, 8'h00);
    check("tmo cycle100 {busy,err,code,run}",
          64'({load_busy, load_err, err_code, cpu_run}), 64'(5'b0_1_10_0));

    // A byte on cycle 99 restarts the count; silence then times out 100 later.
    tick(1, 1, 8'hA5);
    check("resync clears tmo err", 64'({load_busy, load_err, err_code}), 64'(4'b1_0_00));
    tick(1, 1, 8'h30);
    repeat (98) tick(1, 0, 8'h00);
    tick(1, 1, 8'h01);
    check("byte@99 {busy,err}", 64'({load_busy, load_err}), 64'(2'b10));
    repeat (99) tick(1, 0, 8'h00);
    check("restart cycle99 {busy,err}", 64'({load_busy, load_err}), 64'(2'b10));
    tick(1, 0, 8'h00);
    check("restart cycle100 {busy,err,code}",
          64'({load_busy, load_err, err_code}), 64'(4'b0_1_10));

    // A byte on the terminal count wins over the timeout.
    tick(1, 1, 8'hA5);
    tick(1, 1, 8'h30);
    repeat (99) tick(1, 0, 8'h00);
    tick(1, 1, 8'h01);
    check("byte@terminal {busy,err,code}",
          64'({load_busy, load_err, err_code}), 64'(4'b1_0_00));
    tick(0, 0, 8'h00);
    check("final reset outputs",
          64'({mem_we, load_busy, load_done, load_err, err_code, cpu_run, mem_addr}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
